fht_ctrl_param: RTL and testbench
=================================

FHT_CTRL_PARAM -- requirements
Module: fht_ctrl_param

Interface
REQ-001 Parameter LOG_N, default 10: log2 of transform length N = 2^LOG_N; legal range 3..16.
REQ-002 Parameter PIPE_LAT, default 4: butterfly pipeline latency in clocks from read address to write; legal range 1..15.
REQ-003 iCLK  in  1  sole clock; all state changes on rising edge.
REQ-004 iRESET  in  1  asynchronous, active-high reset.
REQ-005 iSTART  in  1  one-cycle request to run a full transform.
REQ-006 iSTOP  in  1  synchronous abort.
REQ-007 oADDR_RD_0..oADDR_RD_3  out  LOG_N each  four butterfly read addresses.
REQ-008 oRD_VALID  out  1  read addresses valid this cycle.
REQ-009 oADDR_WR  out  LOG_N  write base address; oADDR_WR_BIAS  out  LOG_N  spacing of the other three write addresses.
REQ-010 oADDR_COEF  out  LOG_N-2  twiddle ROM address.
REQ-011 oWE_A, oWE_B  out  1 each  write enables for ping-pong banks A and B.
REQ-012 oSTAGE  out  5  current stage; oST_ZERO, oST_LAST  out  1  first/last stage flags.
REQ-013 oRDY  out  1  idle, able to accept iSTART; oDONE  out  1  one-cycle completion pulse.

Function
REQ-014 Stage count STAGES = LOG_N-1; stage s in 0..STAGES-1; span d = 2^s.
REQ-015 FSM states IDLE, READ, DRAIN, DONE; IDLE -> READ on iSTART=1 (stage 0, cnt 0); iSTART outside IDLE ignored.
REQ-016 READ: cnt runs 0..N/4-1, one per clock; oRD_VALID=1; after cnt=N/4-1 -> DRAIN.
REQ-017 Per READ cycle: k = cnt mod d, g = cnt div d, A0 = g*4d + k; oADDR_RD_n = A0 + n*d, n = 0..3 (covers 0..N-1 exactly once per stage).
REQ-018 oADDR_COEF = k << (LOG_N-2-s), truncated to LOG_N-2 bits.
REQ-019 All read, coefficient and flag outputs registered; values for cnt visible in the same cycle oRD_VALID=1.
REQ-020 oADDR_WR = A0 and oADDR_WR_BIAS = d of the read cycle, delayed exactly PIPE_LAT clocks; write enable asserted exactly PIPE_LAT clocks after each oRD_VALID cycle.
REQ-021 Even stage: read bank A, write bank B (oWE_B); odd stage: read B, write A (oWE_A); never both high.
REQ-022 DRAIN lasts exactly PIPE_LAT clocks, no reads; then stage+1 and READ, or DONE if s = STAGES-1.
REQ-023 DONE lasts one clock with oDONE=1, then IDLE; completion occurs STAGES*(N/4+PIPE_LAT) clocks after the READ entry cycle.
REQ-024 oRDY=1 only in IDLE.
REQ-025 oST_ZERO = (s=0); oST_LAST = (s=STAGES-1); oSTAGE = s throughout READ and DRAIN.
REQ-026 iSTOP=1 in any non-IDLE state: next clock IDLE, delay line flushed, oWE_A/oWE_B/oRD_VALID low, no oDONE; iSTOP has priority over iSTART in the same cycle.

Reset
REQ-027 iRESET=1 forces immediately: state IDLE, cnt 0, stage 0, delay line cleared.
REQ-028 Reset values: all addresses 0, oRD_VALID 0, oWE_A 0, oWE_B 0, oSTAGE 0, oST_ZERO 1, oST_LAST 0, oDONE 0, oRDY 1.
REQ-029 Reset asserted mid-transform aborts with no write enable or oDONE afterwards.

Configuration
REQ-030 Macro FHT_CTRL_BITREV_EN defined: in stage 0 only, oADDR_RD_0..3 are bit-reversed over LOG_N bits; oADDR_WR, coefficients and later stages unchanged.
REQ-031 Macro undefined: stage 0 read addresses in natural order per REQ-017.

Verification
REQ-032 LOG_N=4, PIPE_LAT=2, iSTART pulse -> oDONE exactly 18 clocks after READ entry; oRDY low throughout, high the clock after DONE.
REQ-033 LOG_N=4, stage 1, cnt=3 -> read addresses 9,11,13,15; oADDR_COEF=2; oWE_A pulses 2 clocks later with oADDR_WR=9, oADDR_WR_BIAS=2.
REQ-034 LOG_N=4, stage 0, cnt=1, FHT_CTRL_BITREV_EN defined -> reads 2,10,6,14; undefined -> 4,5,6,7; oWE_B with oADDR_WR=4 in both cases.
REQ-035 LOG_N=10, PIPE_LAT=4, every stage -> each address 0..1023 read exactly once; no write enable during the first PIPE_LAT READ clocks of any stage.
REQ-036 iSTOP pulsed in stage 1 READ -> IDLE next clock, oRDY=1, no further oWE_A/oWE_B, no oDONE; new iSTART then runs full 18-clock transform (LOG_N=4, PIPE_LAT=2).
REQ-037 iRESET asserted mid-DRAIN between clock edges -> outputs reach reset values before the next edge; iSTART during READ ignored with unchanged timing.

Source files
------------

// File: rtl/fht_ctrl_param.sv
// Fast Hartley transform address/sequence controller.
//
// Walks LOG_N-1 radix-4 butterfly stages over an N = 2^LOG_N point buffer,
// issuing four read addresses plus a twiddle address per clock, then replays
// the write base/spacing PIPE_LAT clocks later into the opposite ping-pong
// bank.  Even stages read bank A / write bank B, odd stages the reverse.
//
// Build option: define FHT_CTRL_BITREV_EN to bit-reverse the stage-0 read
// addresses (input reordering); write addresses and later stages unaffected.
//
// Ports:
//   iCLK, iRESET (async, active high), iSTART (run request), iSTOP (abort)
//   oADDR_RD_0..3   butterfly read addresses      oRD_VALID   reads valid
//   oADDR_WR        write base address            oADDR_WR_BIAS  write spacing
//   oADDR_COEF      twiddle ROM address           oWE_A/oWE_B bank write enables
//   oSTAGE, oST_ZERO, oST_LAST  stage number and first/last flags
//   oRDY            idle                          oDONE       completion pulse
module fht_ctrl_param #(
  parameter int unsigned LOG_N    = 10,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic             iSTOP,
  output logic [LOG_N-1:0] oADDR_RD_0,
  output logic [LOG_N-1:0] oADDR_RD_1,
  output logic [LOG_N-1:0] oADDR_RD_2,
  output logic [LOG_N-1:0] oADDR_RD_3,
  output logic             oRD_VALID,
  output logic [LOG_N-1:0] oADDR_WR,
  output logic [LOG_N-1:0] oADDR_WR_BIAS,
  output logic [LOG_N-3:0] oADDR_COEF,
  output logic             oWE_A,
  output logic             oWE_B,
  output logic [4:0]       oSTAGE,
  output logic             oST_ZERO,
  output logic             oST_LAST,
  output logic             oRDY,
  output logic             oDONE
);

  localparam int unsigned CW         = LOG_N - 2;
  localparam logic [CW-1:0] CNT_LAST = '1;
  localparam logic [4:0] STAGE_LAST  = 5'(LOG_N - 2);
  localparam logic [3:0] DRAIN_LAST  = 4'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  typedef struct packed {
    logic             we_a;
    logic             we_b;
    logic [LOG_N-1:0] base;
    logic [LOG_N-1:0] span;
  } wr_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [4:0]      stage, stage_nxt;
  logic [3:0]      drain, drain_nxt;
  logic            abort;

  logic [LOG_N-1:0] rd_c [4];
  logic [LOG_N-1:0] rd_q [4];
  logic [CW-1:0]    coef_c, coef_q;
  wr_t              wr_c, wr_q;
  wr_t              pipe [PIPE_LAT];
  logic             in_read;

`ifdef FHT_CTRL_BITREV_EN
  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG_N; i++) r[i] = a[LOG_N-1-i];
    return r;
  endfunction
`endif

  assign abort = iSTOP && (state != IDLE);

  // State register
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state <= IDLE;
      cnt   <= '0;
      stage <= '0;
      drain <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      stage <= stage_nxt;
      drain <= drain_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stage_nxt = stage;
    drain_nxt = drain;
    case (state)
      IDLE: if (iSTART && !iSTOP) begin
        state_nxt = READ;
        cnt_nxt   = '0;
        stage_nxt = '0;
      end
      READ: if (cnt == CNT_LAST) begin
        state_nxt = DRAIN;
        drain_nxt = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      DRAIN: if (drain == DRAIN_LAST) begin
        if (stage == STAGE_LAST) begin
          state_nxt = DONE;
        end else begin
          state_nxt = READ;
          stage_nxt = stage + 5'd1;
          cnt_nxt   = '0;
        end
      end else begin
        drain_nxt = drain + 4'd1;
      end
      DONE: begin
        state_nxt = IDLE;
        stage_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      stage_nxt = '0;
      drain_nxt = '0;
    end
  end

  // Output logic: computed from the next state so the registered outputs line
  // up with the cycle in which that state/count is current.
  always_comb begin
    logic [LOG_N-1:0] cnt_w, span, k, a0, coef_w;
    cnt_w  = LOG_N'(cnt_nxt);
    span   = {{(LOG_N-1){1'b0}}, 1'b1} << stage_nxt;
    k      = cnt_w & (span - 1'b1);
    a0     = ((cnt_w >> stage_nxt) << (stage_nxt + 5'd2)) | k;
    coef_w = k << (5'(CW) - stage_nxt);
    in_read = (state_nxt == READ);

    rd_c[0] = a0;
    rd_c[1] = a0 + span;
    rd_c[2] = a0 + (span << 1);
    rd_c[3] = a0 + span + (span << 1);
`ifdef FHT_CTRL_BITREV_EN
    if (stage_nxt == 5'd0) begin
      for (int unsigned n = 0; n < 4; n++) rd_c[n] = bitrev(rd_c[n]);
    end
`endif
    coef_c = coef_w[CW-1:0];

    wr_c = '0;
    if (in_read) begin
      wr_c.we_a = stage_nxt[0];
      wr_c.we_b = !stage_nxt[0];
      wr_c.base = a0;
      wr_c.span = span;
    end else begin
      for (int unsigned n = 0; n < 4; n++) rd_c[n] = '0;
      coef_c = '0;
    end
  end

  // Output registers and write-back delay line
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      for (int unsigned n = 0; n < 4; n++) rd_q[n] <= '0;
      coef_q    <= '0;
      wr_q      <= '0;
      oRD_VALID <= 1'b0;
      oSTAGE    <= '0;
      oST_ZERO  <= 1'b1;
      oST_LAST  <= 1'b0;
      oRDY      <= 1'b1;
      oDONE     <= 1'b0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
    end else begin
      for (int unsigned n = 0; n < 4; n++) rd_q[n] <= rd_c[n];
      coef_q    <= coef_c;
      wr_q      <= wr_c;
      oRD_VALID <= in_read;
      oSTAGE    <= stage_nxt;
      oST_ZERO  <= (stage_nxt == 5'd0);
      oST_LAST  <= (stage_nxt == STAGE_LAST);
      oRDY      <= (state_nxt == IDLE);
      oDONE     <= (state_nxt == DONE);
      // wr_q holds the write record of the read cycle now on the outputs;
      // it reaches the tail PIPE_LAT clocks later.  Abort drops everything.
      if (abort) begin
        for (int unsigned i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= wr_q;
        for (int unsigned i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
      end
    end
  end

  assign oADDR_RD_0    = rd_q[0];
  assign oADDR_RD_1    = rd_q[1];
  assign oADDR_RD_2    = rd_q[2];
  assign oADDR_RD_3    = rd_q[3];
  assign oADDR_COEF    = coef_q;
  assign oADDR_WR      = pipe[PIPE_LAT-1].base;
  assign oADDR_WR_BIAS = pipe[PIPE_LAT-1].span;
  assign oWE_A         = pipe[PIPE_LAT-1].we_a;
  assign oWE_B         = pipe[PIPE_LAT-1].we_b;

endmodule

// File: tb/tb_fht_ctrl_param.sv
module tb_fht_ctrl_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, start2 = 1'b0;

  always #5 clk = ~clk;

  // Small instance: LOG_N=4, PIPE_LAT=2
  logic [3:0] rd0, rd1, rd2, rd3, wr, bias;
  logic [1:0] coef;
  logic       rdv, wea, web, zero, last, rdy, done;
  logic [4:0] stg;

  fht_ctrl_param #(.LOG_N(4), .PIPE_LAT(2)) dut (
    .iCLK(clk), .iRESET(rst), .iSTART(start), .iSTOP(stop),
    .oADDR_RD_0(rd0), .oADDR_RD_1(rd1), .oADDR_RD_2(rd2), .oADDR_RD_3(rd3),
    .oRD_VALID(rdv), .oADDR_WR(wr), .oADDR_WR_BIAS(bias), .oADDR_COEF(coef),
    .oWE_A(wea), .oWE_B(web), .oSTAGE(stg), .oST_ZERO(zero), .oST_LAST(last),
    .oRDY(rdy), .oDONE(done)
  );

  // Large instance: LOG_N=10, PIPE_LAT=4
  logic [9:0] b_rd0, b_rd1, b_rd2, b_rd3, b_wr, b_bias;
  logic [7:0] b_coef;
  logic       b_rdv, b_wea, b_web, b_zero, b_last, b_rdy, b_done;
  logic [4:0] b_stg;

  fht_ctrl_param #(.LOG_N(10), .PIPE_LAT(4)) dut_big (
    .iCLK(clk), .iRESET(rst), .iSTART(start2), .iSTOP(1'b0),
    .oADDR_RD_0(b_rd0), .oADDR_RD_1(b_rd1), .oADDR_RD_2(b_rd2), .oADDR_RD_3(b_rd3),
    .oRD_VALID(b_rdv), .oADDR_WR(b_wr), .oADDR_WR_BIAS(b_bias), .oADDR_COEF(b_coef),
    .oWE_A(b_wea), .oWE_B(b_web), .oSTAGE(b_stg), .oST_ZERO(b_zero), .oST_LAST(b_last),
    .oRDY(b_rdy), .oDONE(b_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int stage, cnt, r0, r1, r2, r3, coef, wr, bias, web;
  } vec_t;

  typedef struct {
    int rdv, r0, r1, r2, r3, coef, stg, z, l, wea, web, wr, bias, done, rdy;
  } samp_t;

  vec_t  vec [12];
  samp_t slog [20];

  function automatic samp_t capture();
    samp_t s;
    s.rdv = rdv;  s.r0 = rd0; s.r1 = rd1; s.r2 = rd2; s.r3 = rd3;
    s.coef = coef; s.stg = stg; s.z = zero; s.l = last;
    s.wea = wea; s.web = web; s.wr = wr; s.bias = bias;
    s.done = done; s.rdy = rdy;
    return s;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, " rd0"}, rd0, 0);
    chk({tag, " rd3"}, rd3, 0);
    chk({tag, " coef"}, coef, 0);
    chk({tag, " wr"}, wr, 0);
    chk({tag, " bias"}, bias, 0);
    chk({tag, " rd_valid"}, rdv, 0);
    chk({tag, " we_a"}, wea, 0);
    chk({tag, " we_b"}, web, 0);
    chk({tag, " stage"}, stg, 0);
    chk({tag, " st_zero"}, zero, 1);
    chk({tag, " st_last"}, last, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " rdy"}, rdy, 1);
  endtask

  // Pulses start; returns at the negedge of the READ entry cycle.
  task automatic run_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  int seen [9][1024];

  initial begin
    // Stage 0 rows differ with input bit reversal
`ifdef FHT_CTRL_BITREV_EN
    vec[0]  = '{0, 0,  0,  8,  4, 12, 0,  0, 1, 1};
    vec[1]  = '{0, 1,  2, 10,  6, 14, 0,  4, 1, 1};
    vec[2]  = '{0, 2,  1,  9,  5, 13, 0,  8, 1, 1};
    vec[3]  = '{0, 3,  3, 11,  7, 15, 0, 12, 1, 1};
`else
    vec[0]  = '{0, 0,  0,  1,  2,  3, 0,  0, 1, 1};
    vec[1]  = '{0, 1,  4,  5,  6,  7, 0,  4, 1, 1};
    vec[2]  = '{0, 2,  8,  9, 10, 11, 0,  8, 1, 1};
    vec[3]  = '{0, 3, 12, 13, 14, 15, 0, 12, 1, 1};
`endif
    vec[4]  = '{1, 0,  0,  2,  4,  6, 0,  0, 2, 0};
    vec[5]  = '{1, 1,  1,  3,  5,  7, 2,  1, 2, 0};
    vec[6]  = '{1, 2,  8, 10, 12, 14, 0,  8, 2, 0};
    vec[7]  = '{1, 3,  9, 11, 13, 15, 2,  9, 2, 0};
    vec[8]  = '{2, 0,  0,  4,  8, 12, 0,  0, 4, 1};
    vec[9]  = '{2, 1,  1,  5,  9, 13, 1,  1, 4, 1};
    vec[10] = '{2, 2,  2,  6, 10, 14, 2,  2, 4, 1};
    vec[11] = '{2, 3,  3,  7, 11, 15, 3,  3, 4, 1};

    // ---- reset ----
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- full transform, logged per cycle; a stray iSTART during READ ----
    run_start();
    for (int t = 0; t < 20; t++) begin
      slog[t] = capture();
      if (t == 2) start = 1'b1;
      if (t == 3) start = 1'b0;
      @(negedge clk);
    end

    for (int j = 0; j < 12; j++) begin
      int tr, tw;
      tr = vec[j].stage * 6 + vec[j].cnt;
      tw = tr + 2;
      chk($sformatf("rd_valid[%0d]", j), slog[tr].rdv, 1);
      chk($sformatf("rd0[%0d]", j), slog[tr].r0, vec[j].r0);
      chk($sformatf("rd1[%0d]", j), slog[tr].r1, vec[j].r1);
      chk($sformatf("rd2[%0d]", j), slog[tr].r2, vec[j].r2);
      chk($sformatf("rd3[%0d]", j), slog[tr].r3, vec[j].r3);
      chk($sformatf("coef[%0d]", j), slog[tr].coef, vec[j].coef);
      chk($sformatf("stage[%0d]", j), slog[tr].stg, vec[j].stage);
      chk($sformatf("st_zero[%0d]", j), slog[tr].z, int'(vec[j].stage == 0));
      chk($sformatf("st_last[%0d]", j), slog[tr].l, int'(vec[j].stage == 2));
      chk($sformatf("we_b[%0d]", j), slog[tw].web, vec[j].web);
      chk($sformatf("we_a[%0d]", j), slog[tw].wea, 1 - vec[j].web);
      chk($sformatf("wr[%0d]", j), slog[tw].wr, vec[j].wr);
      chk($sformatf("bias[%0d]", j), slog[tw].bias, vec[j].bias);
    end
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("drain_rdv0 s%0d", s), slog[s*6+4].rdv, 0);
      chk($sformatf("drain_rdv1 s%0d", s), slog[s*6+5].rdv, 0);
      chk($sformatf("drain_stage s%0d", s), slog[s*6+5].stg, s);
      chk($sformatf("early_we s%0d", s),
          slog[s*6].wea | slog[s*6].web | slog[s*6+1].wea | slog[s*6+1].web, 0);
    end
    for (int t = 0; t < 20; t++) begin
      chk($sformatf("done t%0d", t), slog[t].done, int'(t == 18));
      chk($sformatf("rdy t%0d", t), slog[t].rdy, int'(t == 19));
    end

    // ---- abort in stage 1 READ, then a fresh run ----
    repeat (2) @(negedge clk);
    run_start();
    repeat (7) @(negedge clk);          // now t=7, stage 1 READ
    chk("stop pre stage", stg, 1);
    chk("stop pre rdv", rdv, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop rdy", rdy, 1);
    chk("stop rdv", rdv, 0);
    chk("stop we", wea | web, 0);
    begin
      int bad = 0;
      for (int t = 0; t < 12; t++) begin
        if (wea || web || done || rdv) bad++;
        @(negedge clk);
      end
      chk("stop quiet", bad, 0);
    end
    run_start();
    begin
      int n = 0;
      int rdy_low = 1;
      while (!done && n < 40) begin
        if (rdy) rdy_low = 0;
        @(negedge clk);
        n++;
      end
      chk("restart done latency", n, 18);
      chk("restart rdy low", rdy_low, 1);
      chk("restart done rdy", rdy, 0);
      @(negedge clk);
      chk("restart rdy after", rdy, 1);
    end

    // ---- async reset in stage 0 DRAIN, between edges ----
    run_start();
    repeat (4) @(negedge clk);          // t=4, DRAIN
    chk("drain we_b", web, 1);
    chk("drain wr", wr, 8);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async rst");
    @(negedge clk) rst = 1'b0;
    begin
      int bad = 0;
      for (int t = 0; t < 20; t++) begin
        if (wea || web || done || !rdy) bad++;
        @(negedge clk);
      end
      chk("post reset quiet", bad, 0);
    end

    // ---- LOG_N=10 coverage ----
    foreach (seen[s, a]) seen[s][a] = 0;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    begin
      int n = 0, viol = 0, rcount = 0, prev = 0, bad_stage = 0;
      while (!b_done && n < 3000) begin
        if (b_rdv) begin
          rcount = prev ? rcount + 1 : 0;
          if (rcount < 4 && (b_wea || b_web)) viol++;
          if (b_stg < 9) begin
            seen[b_stg][b_rd0]++;
            seen[b_stg][b_rd1]++;
            seen[b_stg][b_rd2]++;
            seen[b_stg][b_rd3]++;
          end else begin
            bad_stage++;
          end
        end
        if (b_wea && b_web) viol++;
        prev = b_rdv;
        @(negedge clk);
        n++;
      end
      chk("big done latency", n, 9 * (256 + 4));
      chk("big early we", viol, 0);
      chk("big stage range", bad_stage, 0);
      for (int s = 0; s < 9; s++) begin
        int miss = 0;
        for (int a = 0; a < 1024; a++) if (seen[s][a] != 1) miss++;
        chk($sformatf("big cover s%0d", s), miss, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
